// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and helpers for the clock-switch sequencing controller.
// State encoding depends on CLK_SWITCH_CTRL_QUIESCE_EN (QUIESCE skipped when undefined).
package clk_switch_ctrl_pkg;

`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    SWITCH  = 2'd2,
    DONE    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    DONE   = 2'd2
  } state_e;
`endif

  // Mux worst-case switch delay in clks_i cycles: 2 x sync stages x slowest-period ratio.
  function automatic int unsigned recommended_settle(input int unsigned sync_stages,
                                                     input int unsigned slow_ratio);
    return 2 * sync_stages * slow_ratio;
  endfunction

endpackage

// File: rtl/clk_switch_settle_cnt.sv
// Settle-window down-counter; load covers both the initial load and the abort reload.
// A zero load value is treated as one so the window is never empty.
module clk_switch_settle_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clks_i,
  input  logic                 async_rstn_i,
  input  logic                 load_i,
  input  logic                 dec_i,
  input  logic [CNT_WIDTH-1:0] val_i,
  output logic                 last_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (val_i == '0) ? CNT_WIDTH'(1) : val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // last_o is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clks_i or negedge async_rstn_i) begin
    if (!async_rstn_i) begin
      cnt_q  <= '0;
      last_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_o <= (cnt_d == CNT_WIDTH'(1));
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock mux sequencing controller: validates requests, drives the select, holds settle.
// Optional quiesce handshake enabled by defining CLK_SWITCH_CTRL_QUIESCE_EN.
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS = 2,
  parameter  int unsigned RESET_SEL  = 0,
  parameter  int unsigned CNT_WIDTH  = 8,
  localparam int unsigned SelWidth   = $clog2(NUM_INPUTS)
) (
  input  logic                  clks_i,
  input  logic                  async_rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SelWidth-1:0]   req_sel_i,
  input  logic [NUM_INPUTS-1:0] src_valid_i,
  input  logic [CNT_WIDTH-1:0]  settle_cycles_i,
  output logic [SelWidth-1:0]   sel_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
  ,
  output logic                  quiesce_req_o,
  input  logic                  quiesce_ack_i
`endif
);

  localparam logic [1:0] ST_IDLE    = IDLE;
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
  localparam logic [1:0] ST_QUIESCE = QUIESCE;
`endif
  localparam logic [1:0] ST_SWITCH  = SWITCH;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]           state_q, state_d;
  logic [SelWidth-1:0]  target_q, target_d;
  logic [SelWidth-1:0]  prev_q, prev_d;
  logic [SelWidth-1:0]  sel_d;
  logic [CNT_WIDTH-1:0] settle_q, settle_d;
  logic [CNT_WIDTH-1:0] cnt_val;
  logic                 entry_q, entry_d;
  logic                 aborted_q, aborted_d;
  logic                 err_q, err_d;
  logic                 cnt_load, cnt_dec, cnt_last;
  logic                 sel_ok;

  assign sel_ok  = (32'(req_sel_i) < NUM_INPUTS) && src_valid_i[req_sel_i];
  assign cnt_val = (state_q == ST_IDLE) ? settle_cycles_i : settle_q;

  clk_switch_settle_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_settle_cnt (
    .clks_i       (clks_i),
    .async_rstn_i (async_rstn_i),
    .load_i       (cnt_load),
    .dec_i        (cnt_dec),
    .val_i        (cnt_val),
    .last_o       (cnt_last)
  );

  // Next state and next register values.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    prev_d    = prev_q;
    settle_d  = settle_q;
    entry_d   = entry_q;
    aborted_d = aborted_q;
    err_d     = err_q;
    sel_d     = sel_o;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          if (!sel_ok) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (req_sel_i == sel_o) begin
            state_d = ST_DONE;
            err_d   = 1'b0;
          end else begin
            target_d  = req_sel_i;
            prev_d    = sel_o;
            settle_d  = settle_cycles_i;
            entry_d   = 1'b1;
            aborted_d = 1'b0;
            err_d     = 1'b0;
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
            state_d   = ST_QUIESCE;
`else
            state_d   = ST_SWITCH;
            cnt_load  = 1'b1;
`endif
          end
        end
      end
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
      ST_QUIESCE: begin
        if (quiesce_ack_i) begin
          state_d  = ST_SWITCH;
          cnt_load = 1'b1;
        end
      end
`endif
      ST_SWITCH: begin
        if (entry_q) begin
          sel_d   = target_q;
          entry_d = 1'b0;
        end
        // A lost target reverts the select once and restarts the settle window.
        if (!entry_q && !aborted_q && !src_valid_i[target_q]) begin
          sel_d     = prev_q;
          aborted_d = 1'b1;
          cnt_load  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
            err_d   = aborted_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clks_i or negedge async_rstn_i) begin
    if (!async_rstn_i) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      prev_q        <= '0;
      settle_q      <= '0;
      entry_q       <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      sel_o         <= SelWidth'(RESET_SEL);
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      busy_o        <= 1'b0;
      req_ready_o   <= 1'b1;
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
      quiesce_req_o <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      prev_q        <= prev_d;
      settle_q      <= settle_d;
      entry_q       <= entry_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
      sel_o         <= sel_d;
      done_o        <= (state_q == ST_DONE);
      err_o         <= (state_q == ST_DONE) && err_q;
      busy_o        <= (state_q != ST_IDLE);
      req_ready_o   <= (state_d == ST_IDLE);
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
      quiesce_req_o <= (state_q == ST_QUIESCE) || (state_q == ST_SWITCH);
`endif
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl (default build): edge-timeline model plus directed pins.
module tb_clk_switch_ctrl;

  localparam int unsigned NUM = 2;

  logic       clks_i = 1'b0;
  logic       async_rstn_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [0:0] req_sel_i;
  logic [1:0] src_valid_i;
  logic [7:0] settle_cycles_i;
  logic [0:0] sel_o;
  logic       busy_o, done_o, err_o;
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
  logic       quiesce_req_o;
  logic       quiesce_ack_i = 1'b1;
`endif

  always #5 clks_i = ~clks_i;

  clk_switch_ctrl #(.NUM_INPUTS(2), .RESET_SEL(0), .CNT_WIDTH(8)) dut (
    .clks_i          (clks_i),
    .async_rstn_i    (async_rstn_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_sel_i       (req_sel_i),
    .src_valid_i     (src_valid_i),
    .settle_cycles_i (settle_cycles_i),
    .sel_o           (sel_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
`ifdef CLK_SWITCH_CTRL_QUIESCE_EN
    ,
    .quiesce_req_o   (quiesce_req_o),
    .quiesce_ack_i   (quiesce_ack_i)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction timeline: accepted at edge E, internal completion edge F, outputs lag one edge.
  int   t = 0;
  bit   act = 0, sw = 0, merr = 0;
  int   E = 0, F = 0, N = 0;
  logic tgt = 1'b0, prv = 1'b0, m_sel = 1'b0;
  logic exp_sel, exp_busy, exp_done, exp_err, exp_ready;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, t, got, want);
    end
  endtask

  task automatic model_reset();
    act = 0; m_sel = 1'b0;
    exp_sel = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
  endtask

  task automatic model_edge();
    t++;
    if (act && t > F + 1) act = 0;
    if (!act && req_valid_i && exp_ready) begin
      act = 1; E = t; merr = 0; sw = 0;
      if (32'(req_sel_i) >= NUM || !src_valid_i[req_sel_i]) begin
        merr = 1; F = t;
      end else if (req_sel_i == m_sel) begin
        F = t;
      end else begin
        sw = 1; tgt = req_sel_i; prv = m_sel;
        N = (settle_cycles_i == 8'd0) ? 1 : int'(settle_cycles_i);
        F = t + N;
      end
    end else if (act && sw) begin
      if (t == E + 1) m_sel = tgt;
      if (t >= E + 2 && t <= F && !merr && !src_valid_i[tgt]) begin
        merr = 1; m_sel = prv; F = t + N;
      end
    end
    exp_sel   = m_sel;
    exp_busy  = act && t >= E + 1 && t <= F + 1;
    exp_done  = act && t == F + 1;
    exp_err   = exp_done && merr;
    exp_ready = !(act && t <= F);
  endtask

  task automatic tick();
    @(posedge clks_i);
    if (async_rstn_i) model_edge();
    else model_reset();
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clks_i) begin
    check("sel",   32'(sel_o),       32'(exp_sel));
    check("busy",  32'(busy_o),      32'(exp_busy));
    check("done",  32'(done_o),      32'(exp_done));
    check("err",   32'(err_o),       32'(exp_err));
    check("ready", 32'(req_ready_o), 32'(exp_ready));
  end

  initial begin
    async_rstn_i = 1'b0; req_valid_i = 1'b0; req_sel_i = 1'b0;
    src_valid_i = 2'b11; settle_cycles_i = 8'd0;
    model_reset();
    #12 async_rstn_i = 1'b1;
    check("rst_sel", 32'(sel_o), 0);
    check("rst_ready", 32'(req_ready_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);

    // Invalid target: source 1 absent.
    src_valid_i = 2'b01; req_sel_i = 1'b1; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    check("inv_ready", 32'(req_ready_o), 0);
    check("inv_done0", 32'(done_o), 0);
    tick();
    check("inv_done", 32'(done_o), 1);
    check("inv_err", 32'(err_o), 1);
    check("inv_sel", 32'(sel_o), 0);
    tick();
    check("inv_done_fall", 32'(done_o), 0);
    src_valid_i = 2'b11;

    // Normal switch 0->1, settle 4; settle input changes after acceptance are ignored.
    settle_cycles_i = 8'd4; req_sel_i = 1'b1; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0; settle_cycles_i = 8'd200;
    check("sw_sel_hold", 32'(sel_o), 0);
    tick();
    check("sw_sel", 32'(sel_o), 1);
    check("sw_busy", 32'(busy_o), 1);
    repeat (3) tick();
    check("sw_done_early", 32'(done_o), 0);
    tick();
    check("sw_done", 32'(done_o), 1);
    check("sw_err", 32'(err_o), 0);
    tick();
    check("sw_done_fall", 32'(done_o), 0);
    check("sw_busy_fall", 32'(busy_o), 0);
    check("sw_ready", 32'(req_ready_o), 1);

    // Abort: switch 1->0 with settle 6, source 0 drops three cycles into SWITCH.
    settle_cycles_i = 8'd6; req_sel_i = 1'b0; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    tick();
    check("ab_sel", 32'(sel_o), 0);
    repeat (2) tick();
    src_valid_i = 2'b10;
    tick();
    check("ab_revert", 32'(sel_o), 1);
    src_valid_i = 2'b11;
    repeat (6) tick();
    check("ab_done_early", 32'(done_o), 0);
    tick();
    check("ab_done", 32'(done_o), 1);
    check("ab_err", 32'(err_o), 1);
    tick();

    // Back-to-back with settle 0, then a same-source request, valid held throughout.
    settle_cycles_i = 8'd0; req_sel_i = 1'b0; req_valid_i = 1'b1;
    tick(); req_sel_i = 1'b1;
    tick();
    check("bb_sel0", 32'(sel_o), 0);
    tick();
    check("bb_done1", 32'(done_o), 1);
    tick();
    check("bb_accept2", 32'(req_ready_o), 0);
    tick();
    check("bb_sel1", 32'(sel_o), 1);
    tick();
    check("bb_done2", 32'(done_o), 1);
    tick(); req_valid_i = 1'b0;
    check("bb_accept3", 32'(req_ready_o), 0);
    tick();
    check("same_done", 32'(done_o), 1);
    check("same_err", 32'(err_o), 0);
    check("same_sel", 32'(sel_o), 1);
    tick();

    // Async reset in the middle of a long settle window.
    settle_cycles_i = 8'd20; req_sel_i = 1'b0; req_valid_i = 1'b1;
    tick(); req_valid_i = 1'b0;
    repeat (5) tick();
    #2 async_rstn_i = 1'b0;
    #1;
    model_reset();
    check("arst_sel", 32'(sel_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_ready", 32'(req_ready_o), 1);
    repeat (2) tick();
    #3 async_rstn_i = 1'b1;

    // Randomized traffic with occasional source loss and extreme settle values.
    for (int i = 0; i < 3000; i++) begin
      req_valid_i = ($urandom_range(2, 0) != 0);
      req_sel_i   = 1'($urandom_range(1, 0));
      src_valid_i = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b11;
      settle_cycles_i = ($urandom_range(127, 0) == 0) ? 8'd255 : 8'($urandom_range(7, 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
